// File: rtl/wrap030_dram_pkg.sv
`default_nettype none
// ============================================================================
// wrap030_dram_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the Wrap030 DRAM arbiter and the RAS/CAS sequencer:
// arbiter state encoding, seqOp operation codes and timing defaults.
// Optional feature macro used by the arbiter: WRAP030_DMA_FAIR_EN.
// Revision: 1.0 - initial release
// ============================================================================
package wrap030_dram_pkg;

   typedef enum logic [2:0] {
      sHOLD = 3'd0,   // power-up hold
      sIRFS = 3'd1,   // launch one initial refresh
      sIWT  = 3'd2,   // wait for the initial refresh to finish
      sIDLE = 3'd3,   // arbitrate
      sGNT  = 3'd4,   // drive grant and launch the sequencer
      sWAIT = 3'd5    // hold grant until the sequencer finishes
   } arb_state_t;

   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_CPU  = 2'd1;
   localparam logic [1:0] OP_DMA  = 2'd2;
   localparam logic [1:0] OP_RFSH = 2'd3;

   // 390 cycles is 15.6 us at a 25 MHz bus clock
   localparam int DEF_RFSH_INTERVAL    = 390;
   localparam int DEF_INIT_HOLD        = 7;
   localparam int DEF_INIT_RFSH        = 8;
   localparam int DEF_DMA_STARVE_LIMIT = 4;

endpackage
`default_nettype wire

// File: rtl/wrap030_rfsh_sched.sv
`default_nettype none
// ============================================================================
// wrap030_rfsh_sched
// ----------------------------------------------------------------------------
// Refresh schedule: free-running interval counter (enabled by run), a
// saturating count of outstanding refreshes and a sticky overrun flag.
// Ports:
//   busClk, busReset_n : clock, synchronous active-low reset
//   run                : interval counter enable (initialization complete)
//   taken              : a refresh was granted this cycle
//   pend               : refreshes outstanding (0..3)
//   overrun            : sticky, a refresh was lost while pend was full
// Revision: 1.0 - initial release
// ============================================================================
module wrap030_rfsh_sched
   import wrap030_dram_pkg::*;
#(
   parameter int RFSH_INTERVAL = DEF_RFSH_INTERVAL
) (
   input  logic       busClk,
   input  logic       busReset_n,
   input  logic       run,
   input  logic       taken,
   output logic [1:0] pend,
   output logic       overrun
);

   localparam int CNT_W = (RFSH_INTERVAL > 1) ? $clog2(RFSH_INTERVAL) : 1;

   logic [CNT_W-1:0] ivl_cnt_q, ivl_cnt_d;
   logic [1:0]       pend_q, pend_d;
   logic             overrun_q, overrun_d;
   logic             wrap;

   always_comb begin
      wrap      = run && (ivl_cnt_q == CNT_W'(RFSH_INTERVAL - 1));
      ivl_cnt_d = ivl_cnt_q;
      pend_d    = pend_q;
      overrun_d = overrun_q;

      if (run) begin
         ivl_cnt_d = wrap ? '0 : ivl_cnt_q + CNT_W'(1);
      end

      // A wrap coinciding with a grant cancels out; otherwise a wrap with
      // the pending count already full loses a refresh.
      if (wrap && !taken) begin
         if (pend_q == 2'd3) begin
            overrun_d = 1'b1;
         end else begin
            pend_d = pend_q + 2'd1;
         end
      end else if (taken && !wrap && (pend_q != 2'd0)) begin
         pend_d = pend_q - 2'd1;
      end
   end

   always_ff @(posedge busClk) begin
      if (!busReset_n) begin
         ivl_cnt_q <= '0;
         pend_q    <= 2'd0;
         overrun_q <= 1'b0;
      end else begin
         ivl_cnt_q <= ivl_cnt_d;
         pend_q    <= pend_d;
         overrun_q <= overrun_d;
      end
   end

   assign pend    = pend_q;
   assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: rtl/wrap030_dram_arbiter.sv
`default_nettype none
// ============================================================================
// wrap030_dram_arbiter
// ----------------------------------------------------------------------------
// Shares the DRAM array between CPU cycles, DMA/video and CBR refresh.
// Performs the power-up hold and initial refresh burst, then arbitrates:
// urgent refresh > CPU > DMA > deferred refresh, one operation at a time.
// Optional feature macro: WRAP030_DMA_FAIR_EN - DMA outranks CPU after
// DMA_STARVE_LIMIT consecutive CPU grants made while DMA was waiting.
// Ports:
//   busClk, busReset_n : clock, synchronous active-low reset
//   cpuReq / cpuGnt    : CPU request level / ownership
//   dmaReq / dmaGnt    : DMA request level / ownership
//   seqStart, seqOp    : sequencer launch pulse and operation code
//   seqDone            : sequencer completion pulse
//   rfshPend           : refreshes outstanding
//   rfshOverrun        : sticky lost-refresh flag
//   initDone           : initialization complete
// Revision: 1.0 - initial release
// ============================================================================
module wrap030_dram_arbiter
   import wrap030_dram_pkg::*;
#(
   parameter int RFSH_INTERVAL    = DEF_RFSH_INTERVAL,
   parameter int INIT_HOLD        = DEF_INIT_HOLD,
   parameter int INIT_RFSH        = DEF_INIT_RFSH
`ifdef WRAP030_DMA_FAIR_EN
   ,parameter int DMA_STARVE_LIMIT = DEF_DMA_STARVE_LIMIT
`endif
) (
   input  logic       busClk,
   input  logic       busReset_n,
   input  logic       cpuReq,
   output logic       cpuGnt,
   input  logic       dmaReq,
   output logic       dmaGnt,
   output logic       seqStart,
   output logic [1:0] seqOp,
   input  logic       seqDone,
   output logic [1:0] rfshPend,
   output logic       rfshOverrun,
   output logic       initDone
);

   localparam int HOLD_W = (INIT_HOLD > 1) ? $clog2(INIT_HOLD) : 1;
   localparam int INIT_W = $clog2(INIT_RFSH + 1);

   arb_state_t        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
   logic [1:0]        owner_q, owner_d;
   logic              cpu_gnt_q, cpu_gnt_d;
   logic              dma_gnt_q, dma_gnt_d;
   logic              seq_start_q, seq_start_d;
   logic [1:0]        seq_op_q, seq_op_d;
   logic              init_done_q, init_done_d;

   logic [1:0]        rfsh_pend;
   logic              rfsh_taken;
   logic [1:0]        winner;
   logic              dma_favoured;

`ifdef WRAP030_DMA_FAIR_EN
   localparam int STARVE_W = $clog2(DMA_STARVE_LIMIT + 1);
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

   assign dma_favoured = dmaReq && (starve_cnt_q == STARVE_W'(DMA_STARVE_LIMIT));

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (state_q == sIDLE) begin
         if (winner == OP_DMA) begin
            starve_cnt_d = '0;
         end else if ((winner == OP_CPU) && dmaReq &&
                      (starve_cnt_q != STARVE_W'(DMA_STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
         end
      end
   end

   always_ff @(posedge busClk) begin
      if (!busReset_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign dma_favoured = 1'b0;
`endif

   // Arbitration result; only acted on in sIDLE.
   always_comb begin
      winner = OP_NONE;
      if (rfsh_pend >= 2'd2) begin
         winner = OP_RFSH;
      end else if (dma_favoured) begin
         winner = OP_DMA;
      end else if (cpuReq) begin
         winner = OP_CPU;
      end else if (dmaReq) begin
         winner = OP_DMA;
      end else if (rfsh_pend == 2'd1) begin
         winner = OP_RFSH;
      end
   end

   // The pending count drops at the decision edge, before the refresh runs.
   assign rfsh_taken = (state_q == sIDLE) && (winner == OP_RFSH);

   wrap030_rfsh_sched #(
      .RFSH_INTERVAL (RFSH_INTERVAL)
   ) u_rfsh_sched (
      .busClk     (busClk),
      .busReset_n (busReset_n),
      .run        (init_done_q),
      .taken      (rfsh_taken),
      .pend       (rfsh_pend),
      .overrun    (rfshOverrun)
   );

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      init_cnt_d  = init_cnt_q;
      owner_d     = owner_q;
      cpu_gnt_d   = cpu_gnt_q;
      dma_gnt_d   = dma_gnt_q;
      seq_start_d = 1'b0;
      seq_op_d    = seq_op_q;
      init_done_d = init_done_q;

      case (state_q)
         sHOLD: begin
            if (hold_cnt_q == HOLD_W'(INIT_HOLD - 1)) begin
               state_d = sIRFS;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         sIRFS: begin
            seq_start_d = 1'b1;
            seq_op_d    = OP_RFSH;
            state_d     = sIWT;
         end
         sIWT: begin
            if (seqDone) begin
               seq_op_d   = OP_NONE;
               init_cnt_d = init_cnt_q + INIT_W'(1);
               if (init_cnt_q == INIT_W'(INIT_RFSH - 1)) begin
                  init_done_d = 1'b1;
                  state_d     = sIDLE;
               end else begin
                  state_d = sIRFS;
               end
            end
         end
         sIDLE: begin
            if (winner != OP_NONE) begin
               owner_d = winner;
               state_d = sGNT;
            end
         end
         sGNT: begin
            seq_start_d = 1'b1;
            seq_op_d    = owner_q;
            cpu_gnt_d   = (owner_q == OP_CPU);
            dma_gnt_d   = (owner_q == OP_DMA);
            state_d     = sWAIT;
         end
         sWAIT: begin
            if (seqDone) begin
               cpu_gnt_d = 1'b0;
               dma_gnt_d = 1'b0;
               seq_op_d  = OP_NONE;
               owner_d   = OP_NONE;
               state_d   = sIDLE;
            end
         end
         default: begin
            state_d = sHOLD;
         end
      endcase
   end

   always_ff @(posedge busClk) begin
      if (!busReset_n) begin
         state_q     <= sHOLD;
         hold_cnt_q  <= '0;
         init_cnt_q  <= '0;
         owner_q     <= OP_NONE;
         cpu_gnt_q   <= 1'b0;
         dma_gnt_q   <= 1'b0;
         seq_start_q <= 1'b0;
         seq_op_q    <= OP_NONE;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         init_cnt_q  <= init_cnt_d;
         owner_q     <= owner_d;
         cpu_gnt_q   <= cpu_gnt_d;
         dma_gnt_q   <= dma_gnt_d;
         seq_start_q <= seq_start_d;
         seq_op_q    <= seq_op_d;
         init_done_q <= init_done_d;
      end
   end

   assign cpuGnt   = cpu_gnt_q;
   assign dmaGnt   = dma_gnt_q;
   assign seqStart = seq_start_q;
   assign seqOp    = seq_op_q;
   assign rfshPend = rfsh_pend;
   assign initDone = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_wrap030_dram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wrap030_dram_arbiter
// ----------------------------------------------------------------------------
// Directed bench: a cycle table covering reset, initialization and a
// CPU-then-DMA handover, followed by hand-written multi-cycle sequences for
// refresh urgency, overrun, reset during an operation and CPU/DMA priority.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wrap030_dram_arbiter;
   import wrap030_dram_pkg::*;

   logic       busClk;
   logic       busReset_n;
   logic       cpuReq;
   logic       cpuGnt;
   logic       dmaReq;
   logic       dmaGnt;
   logic       seqStart;
   logic [1:0] seqOp;
   logic       seqDone;
   logic [1:0] rfshPend;
   logic       rfshOverrun;
   logic       initDone;

   int checks   = 0;
   int failures = 0;

   bit seq_auto  = 1'b0;   // sequencer model drives seqDone
   bit seq_block = 1'b0;   // sequencer model never answers new starts

   typedef struct packed {
      logic       cpu_req;
      logic       dma_req;
      logic       seq_done;
      logic       cpu_gnt;
      logic       dma_gnt;
      logic       seq_start;
      logic [1:0] seq_op;
      logic       init_done;
      logic [1:0] pend;
      logic       ovr;
   } vec_t;

   wrap030_dram_arbiter dut (
      .busClk      (busClk),
      .busReset_n  (busReset_n),
      .cpuReq      (cpuReq),
      .cpuGnt      (cpuGnt),
      .dmaReq      (dmaReq),
      .dmaGnt      (dmaGnt),
      .seqStart    (seqStart),
      .seqOp       (seqOp),
      .seqDone     (seqDone),
      .rfshPend    (rfshPend),
      .rfshOverrun (rfshOverrun),
      .initDone    (initDone)
   );

   initial begin
      busClk = 1'b0;
      forever #5 busClk = ~busClk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge busClk);
      #1;
   endtask

   // Sequencer model: seqDone is sampled four edges after the seqStart edge.
   initial begin
      int cd;
      cd = 0;
      forever begin
         @(posedge busClk);
         #1;
         if (seq_auto) begin
            seqDone = 1'b0;
            if (!busReset_n) begin
               cd = 0;
            end else begin
               if (cd > 0) begin
                  cd = cd - 1;
                  if (cd == 0) seqDone = 1'b1;
               end
               if (seqStart && !seq_block) cd = 3;
            end
         end
      end
   end

   initial begin
      vec_t tbl [1:50];
      int   s;
      int   cyc;
      bit   saw2;
      bit   got;
      int   t3;
      int   tov;
      int   k;
      int   nrf;
      bit   early_gnt;
      int   cpu_n;
      int   dma_n;
      int   run_len;

      // ---------------- table: reset release at edge 0 ----------------
      for (int i = 1; i <= 50; i++) begin
         tbl[i]           = '0;
         tbl[i].cpu_req   = (i <= 41);
         tbl[i].dma_req   = (i <= 46);
         tbl[i].init_done = (i >= 39);
      end
      for (int r = 0; r < 8; r++) begin
         s = 8 + 4 * r;
         tbl[s].seq_start   = 1'b1;
         tbl[s].seq_op      = OP_RFSH;
         tbl[s + 1].seq_op  = OP_RFSH;
         tbl[s + 2].seq_op  = OP_RFSH;
         tbl[s + 3].seq_done = 1'b1;
      end
      // spurious seqDone in sHOLD and sIDLE must be ignored
      tbl[3].seq_done  = 1'b1;
      tbl[45].seq_done = 1'b1;
      tbl[50].seq_done = 1'b1;
      // CPU wins over DMA: decision at edge 40, grant at 41
      tbl[41].cpu_gnt = 1'b1; tbl[41].seq_start = 1'b1; tbl[41].seq_op = OP_CPU;
      tbl[42].cpu_gnt = 1'b1; tbl[42].seq_op = OP_CPU;
      tbl[43].cpu_gnt = 1'b1; tbl[43].seq_op = OP_CPU;
      tbl[44].seq_done = 1'b1;
      // DMA granted two edges after the CPU seqDone
      tbl[46].dma_gnt = 1'b1; tbl[46].seq_start = 1'b1; tbl[46].seq_op = OP_DMA;
      tbl[47].dma_gnt = 1'b1; tbl[47].seq_op = OP_DMA;
      tbl[48].dma_gnt = 1'b1; tbl[48].seq_op = OP_DMA;
      tbl[49].seq_done = 1'b1;

      busReset_n = 1'b0;
      cpuReq     = 1'b0;
      dmaReq     = 1'b0;
      seqDone    = 1'b0;
      tick();
      tick();
      chk("reset_state", 32'({cpuGnt, dmaGnt, seqStart, seqOp, initDone, rfshPend, rfshOverrun}), 32'd0);
      busReset_n = 1'b1;

      for (int i = 1; i <= 50; i++) begin
         cpuReq  = tbl[i].cpu_req;
         dmaReq  = tbl[i].dma_req;
         seqDone = tbl[i].seq_done;
         tick();
         chk($sformatf("vec%0d", i),
             32'({cpuGnt, dmaGnt, seqStart, seqOp, initDone, rfshPend, rfshOverrun}),
             32'({tbl[i].cpu_gnt, tbl[i].dma_gnt, tbl[i].seq_start, tbl[i].seq_op,
                  tbl[i].init_done, tbl[i].pend, tbl[i].ovr}));
      end
      seqDone  = 1'b0;
      seq_auto = 1'b1;

      // ---------------- urgent refresh overtakes a held CPU request ----------------
      cpuReq = 1'b1;
      dmaReq = 1'b0;
      saw2   = 1'b0;
      got    = 1'b0;
      cpu_n  = 0;
      for (cyc = 0; cyc < 1500 && !got; cyc++) begin
         tick();
         if (rfshPend == 2'd2) saw2 = 1'b1;
         if (seqStart && seqOp == OP_CPU) cpu_n++;
         if (seqStart && seqOp == OP_RFSH) begin
            got = 1'b1;
            chk("urgent_after_pend2", 32'(saw2), 32'd1);
            chk("pend_after_urgent", 32'(rfshPend), 32'd1);
         end
      end
      chk("urgent_rfsh_seen", 32'(got), 32'd1);
      chk("cpu_served_before_urgent", 32'(cpu_n > 50), 32'd1);

      // deferred refresh is taken once nothing else is requesting
      cpuReq = 1'b0;
      for (cyc = 0; cyc < 30 && rfshPend != 2'd0; cyc++) tick();
      chk("deferred_rfsh_taken", 32'(rfshPend), 32'd0);
      for (int i = 0; i < 10; i++) tick();

      // ---------------- blocked sequencer: saturation and overrun ----------------
      seq_block = 1'b1;
      cpuReq    = 1'b1;
      t3  = -1;
      tov = -1;
      for (cyc = 0; cyc < 4 * 390 + 40 && tov < 0; cyc++) begin
         tick();
         if (rfshPend == 2'd3 && t3 < 0) t3 = cyc;
         if (rfshOverrun && tov < 0) tov = cyc;
      end
      chk("overrun_set", 32'(rfshOverrun), 32'd1);
      chk("overrun_one_interval_after_sat", 32'(tov - t3), 32'd390);
      chk("pend_saturated", 32'(rfshPend), 32'd3);
      for (int i = 0; i < 400; i++) tick();
      chk("pend_stays_saturated", 32'(rfshPend), 32'd3);
      chk("cpu_still_owner", 32'(cpuGnt), 32'd1);

      // finish the stuck CPU cycle by hand, then let refreshes drain
      seq_auto  = 1'b0;
      seq_block = 1'b0;
      seqDone   = 1'b1;
      tick();
      seqDone   = 1'b0;
      seq_auto  = 1'b1;
      cpuReq    = 1'b0;
      for (int i = 0; i < 60; i++) tick();
      chk("pend_drained", 32'(rfshPend), 32'd0);
      chk("overrun_sticky", 32'(rfshOverrun), 32'd1);

      // ---------------- reset during sWAIT ----------------
      cpuReq = 1'b1;
      got    = 1'b0;
      for (cyc = 0; cyc < 30 && !got; cyc++) begin
         tick();
         if (cpuGnt) got = 1'b1;
      end
      chk("cpu_grant_before_reset", 32'(got), 32'd1);
      busReset_n = 1'b0;
      tick();
      chk("reset_mid_op", 32'({cpuGnt, dmaGnt, seqStart, seqOp, initDone, rfshPend, rfshOverrun}), 32'd0);
      busReset_n = 1'b1;
      k = 0;
      got = 1'b0;
      while (k < 20 && !got) begin
         tick();
         k++;
         if (seqStart) got = 1'b1;
      end
      chk("reinit_first_start_edge", 32'(k), 32'd8);
      chk("reinit_first_op", 32'(seqOp), 32'(OP_RFSH));
      nrf = 1;
      early_gnt = 1'b0;
      for (cyc = 0; cyc < 200 && !initDone; cyc++) begin
         tick();
         if (seqStart && seqOp == OP_RFSH) nrf++;
         if (cpuGnt) early_gnt = 1'b1;
      end
      chk("reinit_done", 32'(initDone), 32'd1);
      chk("reinit_refresh_count", 32'(nrf), 32'd8);
      chk("no_cpu_grant_during_init", 32'(early_gnt), 32'd0);
      tick();
      tick();
      chk("cpu_grant_after_init", 32'({cpuGnt, seqOp}), 32'({1'b1, OP_CPU}));

      // ---------------- both requesters held ----------------
      dmaReq  = 1'b1;
      cpu_n   = 0;
      dma_n   = 0;
      run_len = 0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (seqStart && seqOp == OP_CPU) begin
            cpu_n++;
            run_len++;
         end
         if (seqStart && seqOp == OP_DMA) begin
            dma_n++;
`ifdef WRAP030_DMA_FAIR_EN
            chk("fair_cpu_run_before_dma", 32'(run_len), 32'd4);
`endif
            run_len = 0;
         end
      end
`ifdef WRAP030_DMA_FAIR_EN
      chk("fair_dma_served", 32'(dma_n > 3), 32'd1);
`else
      chk("strict_no_dma", 32'(dma_n), 32'd0);
`endif
      chk("cpu_served_with_dma", 32'(cpu_n > 15), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
